xgmii_loopback_chan: RTL

//  Parametrised XGMII loopback channel placed between xge_mac xgmii_txd/txc and xgmii_rxd/rxc.

---
 rtl/xgmii_pkg.sv | 10 +
 rtl/xgmii_delay_line.sv | 29 ++
 rtl/xgmii_loopback_chan.sv | 85 ++++++++
 3 files changed

// File: rtl/xgmii_pkg.sv
// xgmii_pkg: XGMII control characters and shared loopback-channel types
package xgmii_pkg;
  localparam logic [7:0] XGMII_IDLE = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM = 8'hFD;
  localparam logic [7:0] XGMII_ERR = 8'hFE;
  localparam logic [31:0] XGMII_LF_SEQ = 32'h0100009C;
  typedef enum logic [1:0] {M_PASS, M_ERR_INJ, M_FORCE_IDLE, M_FORCE_LF} lb_mode_e;
  typedef enum logic {S_IDLE, S_FRAME} in_state_e;
endpackage

// File: rtl/xgmii_delay_line.sv
// xgmii_delay_line: circular-buffer delay of 0..DEPTH-1 beats, load latches delay and refills with FILL
module xgmii_delay_line #(
  parameter int W = 72,
  parameter int DEPTH = 16,
  parameter logic [W-1:0] FILL = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_i,
  input  logic [$clog2(DEPTH)-1:0] delay_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, dly_q, rd_ptr;
  always_ff @(posedge clk) begin
    if (rst || load_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= FILL;
      dly_q <= rst ? '0 : delay_i;
    end else begin
      mem_q[wr_ptr_q] <= din_i;
    end
    wr_ptr_q <= rst ? '0 : wr_ptr_q + AW'(1);
  end
  assign rd_ptr = wr_ptr_q - dly_q;
  // zero delay bypasses storage so the output register alone gives one cycle
  assign dout_o = (dly_q == '0) ? din_i : mem_q[rd_ptr];
endmodule

// File: rtl/xgmii_loopback_chan.sv
// xgmii_loopback_chan: XGMII loopback with programmable latency, frame/error counting,
// single-shot error injection and forced IDLE / LOCAL-FAULT output modes
module xgmii_loopback_chan
  import xgmii_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = DATA_W / 8,
  parameter int MAX_DELAY = 16,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_W-1:0]            xgmii_txd,
  input  logic [CTRL_W-1:0]            xgmii_txc,
  output logic [DATA_W-1:0]            xgmii_rxd,
  output logic [CTRL_W-1:0]            xgmii_rxc,
  input  logic [1:0]                   cfg_mode,
  input  logic [$clog2(MAX_DELAY)-1:0] cfg_delay,
  input  logic                         cfg_load,
  input  logic [CNT_W-1:0]             cfg_err_frame,
  input  logic [7:0]                   cfg_err_beat,
  output logic [CNT_W-1:0]             frame_cnt,
  output logic [CNT_W-1:0]             err_cnt,
  output logic                         in_frame
);
  localparam int W = DATA_W + CTRL_W;
  localparam int HI = (DATA_W == 64) ? 4 : 0;
  localparam logic [W-1:0] IDLE_BEAT = {{CTRL_W{1'b1}}, {CTRL_W{XGMII_IDLE}}};
  localparam logic [W-1:0] LF_BEAT = {{(DATA_W/32){4'b0001}}, {(DATA_W/32){XGMII_LF_SEQ}}};
  in_state_e state_q, state_d;
  lb_mode_e mode;
  logic [7:0] beat_q, beat_d, cur_beat;
  logic [CNT_W-1:0] frame_cnt_q, err_cnt_q, frame_idx;
  logic injected_q, injected_d, drop_q, drop_d, start, term, active, inj;
  logic [W-1:0] wr_beat, dl_out, out_q, out_d;
  assign mode = lb_mode_e'(cfg_mode);
  always_comb begin
    start = (xgmii_txc[0] && xgmii_txd[7:0] == XGMII_START) ||
            (xgmii_txc[HI] && xgmii_txd[8*HI +: 8] == XGMII_START);
    term = 1'b0;
    for (int l = 0; l < CTRL_W; l++) term = term | (xgmii_txc[l] && xgmii_txd[8*l +: 8] == XGMII_TERM);
    active = start || state_q == S_FRAME;
    cur_beat = start ? 8'd0 : (beat_q == 8'hFF ? beat_q : beat_q + 8'd1);
    frame_idx = start ? frame_cnt_q : frame_cnt_q - CNT_W'(1);
    inj = mode == M_ERR_INJ && active && !term && (start || !injected_q) &&
          frame_idx == cfg_err_frame && cur_beat == cfg_err_beat;
    state_d = (active && !term) ? S_FRAME : S_IDLE;
    beat_d = active ? cur_beat : beat_q;
    injected_d = (injected_q && !start) || inj;
    drop_d = drop_q && !start && !term;
    // beats of a frame cut short by reset or reload are replaced until its terminator
    wr_beat = (drop_q && !start) ? IDLE_BEAT :
              {xgmii_txc[CTRL_W-1:1], xgmii_txc[0] | inj, xgmii_txd[DATA_W-1:8], inj ? XGMII_ERR : xgmii_txd[7:0]};
    out_d = (cfg_load || mode == M_FORCE_IDLE) ? IDLE_BEAT : mode == M_FORCE_LF ? LF_BEAT : dl_out;
  end
  always_ff @(posedge clk) begin
    if (rst || cfg_load) begin
      state_q <= S_IDLE;
      beat_q <= '0;
      injected_q <= 1'b0;
      drop_q <= active && !term;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      injected_q <= injected_d;
      drop_q <= drop_d;
    end
    if (rst) begin
      frame_cnt_q <= '0;
      err_cnt_q <= '0;
      out_q <= IDLE_BEAT;
    end else begin
      frame_cnt_q <= frame_cnt_q + CNT_W'(start && !(&frame_cnt_q));
      err_cnt_q <= err_cnt_q + CNT_W'(inj && !cfg_load && !(&err_cnt_q));
      out_q <= out_d;
    end
  end
  xgmii_delay_line #(.W(W), .DEPTH(MAX_DELAY), .FILL(IDLE_BEAT)) u_dl (
    .clk(clk), .rst(rst), .load_i(cfg_load), .delay_i(cfg_delay), .din_i(wr_beat), .dout_o(dl_out)
  );
  assign {xgmii_rxc, xgmii_rxd} = out_q;
  assign frame_cnt = frame_cnt_q;
  assign err_cnt = err_cnt_q;
  assign in_frame = state_q == S_FRAME;
endmodule
